// File: rtl/viscosity_pkg.sv
// ---------------------------------------------------------------------------
// viscosity_pkg
// Shared constants and types for the viscosity DSP scheduler slice.
//   NUM_CH_DEF    default number of ADC sensor channels (power of 2)
//   CH_W          width of a channel index
//   DATA_W        ADC sample width
//   COEF_W        coefficient width (unsigned)
//   SHIFT         right shift applied to the product before 16-bit extraction
//   RES_W         result / pump_ctrl word width
//   PROD_W        full product width (DATA_W + COEF_W)
//   DEFAULT_COEF  coefficient value loaded into every channel at reset
//   stage_t       one pipeline stage: valid flag, channel id, payload bits
//   scale_sat()   shift a product down and saturate it to RES_W bits
// ---------------------------------------------------------------------------
package viscosity_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CH_W       = $clog2(NUM_CH_DEF);
  localparam int DATA_W     = 16;
  localparam int COEF_W     = 18;
  localparam int SHIFT      = 10;
  localparam int RES_W      = 16;
  localparam int PROD_W     = DATA_W + COEF_W;

  localparam logic [COEF_W-1:0] DEFAULT_COEF = 18'h02000;

  // The payload is wide enough for either {sample, coef} in the first stage
  // or the full product in the second stage, since both are PROD_W bits.
  typedef struct packed {
    logic              valid;
    logic [CH_W-1:0]   ch;
    logic [PROD_W-1:0] payload;
  } stage_t;

  // Any bit left above the result width after shifting means the value
  // does not fit, so the result clamps to all ones.
  function automatic logic [RES_W-1:0] scale_sat(input logic [PROD_W-1:0] product);
    logic [PROD_W-1:0] scaled;
    scaled = product >> SHIFT;
    if (|scaled[PROD_W-1:RES_W]) begin
      return '1;
    end
    return scaled[RES_W-1:0];
  endfunction

endpackage

// File: rtl/viscosity_rr_arbiter.sv
// ---------------------------------------------------------------------------
// viscosity_rr_arbiter
// Combinational round-robin arbiter. Grants the first requesting channel
// found when searching upward from the pointer, wrapping at NUM_CH.
//   req          in   NUM_CH  per-channel request (sample valid)
//   enable       in   1       0 forces all grants low
//   pointer      in   CH_W    channel with highest priority this cycle
//   grant        out  NUM_CH  one-hot grant, or zero when nothing granted
//   grant_idx    out  CH_W    encoded index of the granted channel
//   grant_valid  out  1       a grant is being issued this cycle
// ---------------------------------------------------------------------------
module viscosity_rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic              enable,
  input  logic [CH_W-1:0]   pointer,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_valid
);

  // Walking the offsets from farthest to nearest lets the nearest requester
  // overwrite any earlier hit, so the final value is the first one found
  // from the pointer. The index addition wraps because NUM_CH is a power of 2.
  always_comb begin
    logic [CH_W-1:0] idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    if (enable) begin
      for (int off = NUM_CH - 1; off >= 0; off--) begin
        idx = pointer + CH_W'(off);
        if (req[idx]) begin
          grant_idx   = idx;
          grant_valid = 1'b1;
        end
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/viscosity_dsp_scheduler.sv
// ---------------------------------------------------------------------------
// viscosity_dsp_scheduler
// Shares one multiply-and-scale pipeline across NUM_CH ADC sensor channels.
// A round-robin arbiter accepts one sample per cycle; each sample is
// multiplied by its channel's programmable coefficient, shifted down by
// SHIFT and saturated to 16 bits. The latest result per channel is latched
// into a pump_ctrl word for the pump drivers.
//   clk           in   1               system clock
//   rst           in   1               synchronous active-high reset
//   enable        in   1               1 = grant new samples, 0 = drain only
//   ch_valid      in   NUM_CH          per-channel sample valid
//   ch_data       in   NUM_CH*DATA_W   samples, ch i at [i*DATA_W +: DATA_W]
//   ch_ready      out  NUM_CH          one-hot (or zero) grant
//   coef_wr_en    in   1               coefficient write strobe
//   coef_wr_ch    in   CH_W            coefficient write target channel
//   coef_wr_data  in   COEF_W          new coefficient value
//   res_valid     out  1               one-cycle pulse per result
//   res_ch        out  CH_W            channel of the result
//   res_data      out  16              scaled, saturated result
//   pump_ctrl     out  NUM_CH*16       last result per channel
//   busy          out  1               any pipeline stage holds valid data
// The stage_t channel field is sized from the package default, so a
// different channel count is chosen by changing NUM_CH_DEF in the package.
// ---------------------------------------------------------------------------
module viscosity_dsp_scheduler
  import viscosity_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic                     coef_wr_en,
  input  logic [IDX_W-1:0]         coef_wr_ch,
  input  logic [COEF_W-1:0]        coef_wr_data,
  output logic                     res_valid,
  output logic [IDX_W-1:0]         res_ch,
  output logic [RES_W-1:0]         res_data,
  output logic [NUM_CH*RES_W-1:0]  pump_ctrl,
  output logic                     busy
);

  logic [IDX_W-1:0]  rr_ptr;
  logic [NUM_CH-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;
  logic [DATA_W-1:0] grant_sample;

  logic [COEF_W-1:0] coef_q [NUM_CH];
  logic [RES_W-1:0]  pump_q [NUM_CH];

  stage_t            s1_q;
  stage_t            s2_q;
  logic [DATA_W-1:0] s1_sample;
  logic [COEF_W-1:0] s1_coef;
  logic [PROD_W-1:0] s1_product;
  logic [RES_W-1:0]  s2_result;

  // Grants are suppressed during reset so no sample is accepted on a cycle
  // whose pipeline state is about to be cleared.
  viscosity_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arbiter (
    .req         (ch_valid),
    .enable      (enable & ~rst),
    .pointer     (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign ch_ready     = grant;
  assign grant_sample = ch_data[grant_idx*DATA_W +: DATA_W];

  // Pointer moves just past the channel that transferred, giving every
  // other requester priority next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= grant_idx + IDX_W'(1);
    end
  end

  // The first stage samples coef_q before this edge's write lands, so a
  // transfer in the same cycle as a write to its channel uses the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        coef_q[i] <= DEFAULT_COEF;
      end
    end else if (coef_wr_en) begin
      coef_q[coef_wr_ch] <= coef_wr_data;
    end
  end

  assign s1_sample  = s1_q.payload[PROD_W-1 -: DATA_W];
  assign s1_coef    = s1_q.payload[COEF_W-1:0];
  assign s1_product = {{COEF_W{1'b0}}, s1_sample} * {{DATA_W{1'b0}}, s1_coef};
  assign s2_result  = scale_sat(s2_q.payload);

  // Three-stage datapath with no stall path: capture, multiply, scale.
  // Payloads load every cycle; only the valid bits carry meaning.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_data  <= '0;
    end else begin
      s1_q.valid   <= grant_valid;
      s1_q.ch      <= grant_idx;
      s1_q.payload <= {grant_sample, coef_q[grant_idx]};

      s2_q.valid   <= s1_q.valid;
      s2_q.ch      <= s1_q.ch;
      s2_q.payload <= s1_product;

      res_valid    <= s2_q.valid;
      if (s2_q.valid) begin
        res_ch   <= s2_q.ch;
        res_data <= s2_result;
      end
    end
  end

  // Pump words update on the same edge that raises res_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pump_q[i] <= '0;
      end
    end else if (s2_q.valid) begin
      pump_q[s2_q.ch] <= s2_result;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pump_flat
    assign pump_ctrl[g*RES_W +: RES_W] = pump_q[g];
  end

  assign busy = s1_q.valid | s2_q.valid | res_valid;

endmodule

// File: tb/tb_viscosity_dsp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_viscosity_dsp_scheduler
// Directed scenarios followed by randomized traffic, checked cycle by cycle
// against a transaction-level model: expected results are queued with the
// cycle they must appear in, computed with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_viscosity_dsp_scheduler;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [N-1:0]  ch_valid;
  logic [N*16-1:0] ch_data;
  logic [N-1:0]  ch_ready;
  logic          coef_wr_en;
  logic [1:0]    coef_wr_ch;
  logic [17:0]   coef_wr_data;
  logic          res_valid;
  logic [1:0]    res_ch;
  logic [15:0]   res_data;
  logic [N*16-1:0] pump_ctrl;
  logic          busy;

  viscosity_dsp_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .ch_valid     (ch_valid),
    .ch_data      (ch_data),
    .ch_ready     (ch_ready),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_ch   (coef_wr_ch),
    .coef_wr_data (coef_wr_data),
    .res_valid    (res_valid),
    .res_ch       (res_ch),
    .res_data     (res_data),
    .pump_ctrl    (pump_ctrl),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int due;
    int ch;
    int val;
  } pend_t;

  pend_t  pendQ[$];
  int     cyc;
  int     mPtr;
  longint mCoef [N];
  int     mPump [N];
  int     mResCh;
  int     mResData;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void modelReset();
    pendQ.delete();
    mPtr     = 0;
    mResCh   = 0;
    mResData = 0;
    for (int i = 0; i < N; i++) begin
      mCoef[i] = 64'h2000;
      mPump[i] = 0;
    end
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check the
  // combinational grant, then advance the model across the coming edge.
  task automatic applyStimulus(input bit r, input bit en, input logic [N-1:0] v,
                               input logic [N*16-1:0] d, input bit we,
                               input int wch, input int wd);
    int          g;
    bit          expRv;
    logic [N-1:0] expReady;
    logic [63:0] expPump;
    longint      sample;
    longint      scaled;
    pend_t       p;

    @(negedge clk);
    expRv = 1'b0;
    if (pendQ.size() > 0 && pendQ[0].due == cyc) begin
      p        = pendQ.pop_front();
      expRv    = 1'b1;
      mResCh   = p.ch;
      mResData = p.val;
      mPump[p.ch] = p.val;
    end
    expPump = '0;
    for (int i = 0; i < N; i++) begin
      expPump[i*16 +: 16] = mPump[i][15:0];
    end
    checkOutput("res_valid", 64'(res_valid), 64'(expRv));
    checkOutput("res_ch", 64'(res_ch), 64'(mResCh));
    checkOutput("res_data", 64'(res_data), 64'(mResData));
    checkOutput("pump_ctrl", pump_ctrl, expPump);
    checkOutput("busy", 64'(busy), 64'((pendQ.size() > 0) || expRv));

    rst          = r;
    enable       = en;
    ch_valid     = v;
    ch_data      = d;
    coef_wr_en   = we;
    coef_wr_ch   = wch[1:0];
    coef_wr_data = wd[17:0];
    #1;

    g = -1;
    if (!r && en) begin
      for (int off = 0; off < N; off++) begin
        if (g < 0 && v[(mPtr + off) % N]) g = (mPtr + off) % N;
      end
    end
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    checkOutput("ch_ready", 64'(ch_ready), 64'(expReady));

    if (r) begin
      modelReset();
    end else begin
      if (g >= 0) begin
        sample = longint'(d[g*16 +: 16]);
        scaled = (sample * mCoef[g]) / 1024;
        p.due  = cyc + 3;
        p.ch   = g;
        p.val  = (scaled > 65535) ? 65535 : int'(scaled);
        pendQ.push_back(p);
        mPtr   = (g + 1) % N;
      end
      if (we) mCoef[wch] = longint'(wd);
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) applyStimulus(0, en, '0, '0, 0, 0, 0);
  endtask

  logic [N*16-1:0] rd;
  logic [N-1:0]    rv;

  initial begin
    rst = 1'b1; enable = 1'b0; ch_valid = '0; ch_data = '0;
    coef_wr_en = 1'b0; coef_wr_ch = '0; coef_wr_data = '0;
    cyc = 0;
    modelReset();
    repeat (3) @(posedge clk);

    $display("[TB] scenario 1: single sample with default coefficient");
    applyStimulus(1, 1, '0, '0, 0, 0, 0);
    idle(2, 1);
    applyStimulus(0, 1, 4'b0001, 64'h0000_0000_0000_0400, 0, 0, 0);
    idle(4, 1);
    checkOutput("s1_pump0", 64'(pump_ctrl[15:0]), 64'h2000);

    $display("[TB] scenario 2: all channels requesting");
    applyStimulus(1, 1, '0, '0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 4'b1111, {$urandom, $urandom}, 0, 0, 0);
    idle(4, 1);

    $display("[TB] scenario 3: saturation");
    applyStimulus(0, 1, 4'b0100, 64'h0000_FFFF_0000_0000, 0, 0, 0);
    idle(4, 1);
    checkOutput("s3_res_data", 64'(res_data), 64'hFFFF);

    $display("[TB] scenario 4: coefficient write racing a transfer");
    applyStimulus(0, 1, 4'b0010, 64'h0000_0000_0400_0000, 1, 1, 18'h04000);
    idle(1, 1);
    applyStimulus(0, 1, 4'b0010, 64'h0000_0000_0400_0000, 0, 0, 0);
    idle(4, 1);
    checkOutput("s4_pump1", 64'(pump_ctrl[31:16]), 64'h4000);

    $display("[TB] scenario 5: reset with samples in flight");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'b1111, {$urandom, $urandom}, 0, 0, 0);
    applyStimulus(1, 1, 4'b1111, {$urandom, $urandom}, 0, 0, 0);
    idle(5, 1);
    checkOutput("s5_pump_zero", pump_ctrl, 64'h0);

    $display("[TB] scenario 6: enable low drains the pipeline");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'b1111, {$urandom, $urandom}, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 4'b1111, {$urandom, $urandom}, 0, 0, 0);
    checkOutput("s6_busy_low", 64'(busy), 64'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 4'b1111, {$urandom, $urandom}, 0, 0, 0);
    idle(4, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      rd = {$urandom, $urandom};
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 1) == 0) rd[c*16 +: 16] = rd[c*16 +: 16] & 16'h03FF;
      end
      rv = 4'($urandom);
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0), rv, rd,
                    ($urandom_range(0, 5) == 0), int'($urandom_range(0, N - 1)),
                    int'($urandom_range(0, 18'h07FFF)));
    end
    idle(5, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
